// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART definitions: receiver state encodings, parity modes and the
// parity helper, common to the receive and transmit paths.
package uart_rx_deserializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Expected parity bit given the XOR of the data bits and the parity mode.
    function automatic logic parity_expected(input logic ones_odd, input int mode);
        return (mode == PARITY_ODD) ? ~ones_odd : ones_odd;
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_majority3.sv
// Three-input majority voter used to de-glitch the serial line at bit centres.
module uart_rx_deserializer_majority3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end on the oversampling clock: start detect, bit-centre
// timing, optional majority vote, LSB-first deserialise, parity and stop checks.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int SAMPLE_RATIO = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MAJORITY     = 1
) (
    input  logic                 sample_clk,
    input  logic                 rst_n,
    input  logic                 din,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 sample_sig,
    output logic                 busy
);

    // state   | meaning
    // IDLE    | line idle, waiting for a low sample
    // START   | timing to start-bit centre, rejecting glitches
    // DATA    | capturing DATA_BITS data bits at bit centres
    // PARITY  | checking the parity bit
    // STOP    | checking STOP_BITS stop bits, then delivering the word
    // BRK     | line held low after the frame, waiting for it to go high

    localparam int HALF  = SAMPLE_RATIO / 2;
    localparam int CNT_W = $clog2(SAMPLE_RATIO);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(SAMPLE_RATIO - 1);
    localparam logic [3:0]       IDX_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       IDX_STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_e            state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [3:0]           idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 perr_acc, perr_acc_nxt;
    logic                 ferr_acc, ferr_acc_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 data_valid_nxt;
    logic                 parity_err_nxt;
    logic                 frame_err_nxt;
    logic                 sample_sig_nxt;
    logic                 din_q1, din_q2;
    logic                 vote_maj, vote;
    logic                 bit_end;

    uart_rx_deserializer_majority3 u_vote (
        .a (din),
        .b (din_q1),
        .c (din_q2),
        .y (vote_maj)
    );

    assign vote    = (MAJORITY != 0) ? vote_maj : din;
    assign bit_end = (cnt == CNT_BIT_LAST);
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + 1'b1;
        idx_nxt        = idx;
        shreg_nxt      = shreg;
        perr_acc_nxt   = perr_acc;
        ferr_acc_nxt   = ferr_acc;
        data_nxt       = data;
        data_valid_nxt = 1'b0;
        parity_err_nxt = parity_err;
        frame_err_nxt  = frame_err;
        sample_sig_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!din) begin
                    state_nxt      = ST_START;
                    perr_acc_nxt   = 1'b0;
                    ferr_acc_nxt   = 1'b0;
                    parity_err_nxt = 1'b0;
                    frame_err_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    state_nxt = vote ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_nxt        = '0;
                    shreg_nxt      = {vote, shreg[DATA_BITS-1:1]};
                    sample_sig_nxt = 1'b1;
                    if (idx == IDX_DATA_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_STOP;
                    if (vote != parity_expected(^shreg, PARITY)) begin
                        perr_acc_nxt = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (!vote) begin
                        ferr_acc_nxt = 1'b1;
                    end
                    if (idx == IDX_STOP_LAST) begin
                        idx_nxt        = '0;
                        data_nxt       = shreg;
                        data_valid_nxt = 1'b1;
                        parity_err_nxt = perr_acc;
                        frame_err_nxt  = ferr_acc | ~vote;
                        // A low final stop sample means the line may be in break.
                        state_nxt      = vote ? ST_IDLE : ST_BRK;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            ST_BRK: begin
                cnt_nxt = '0;
                if (din) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            sample_sig <= 1'b0;
            din_q1     <= 1'b1;
            din_q2     <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shreg      <= shreg_nxt;
            perr_acc   <= perr_acc_nxt;
            ferr_acc   <= ferr_acc_nxt;
            data       <= data_nxt;
            data_valid <= data_valid_nxt;
            parity_err <= parity_err_nxt;
            frame_err  <= frame_err_nxt;
            sample_sig <= sample_sig_nxt;
            din_q1     <= din;
            din_q2     <= din_q1;
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench: three receiver configurations driven with directed and random
// frames; a monitor compares each delivered word against the reference frame model.
module tb_uart_rx_deserializer;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din   [NI];
    logic [7:0] data  [NI];
    logic       dv    [NI];
    logic       pe    [NI];
    logic       fe    [NI];
    logic       ss    [NI];
    logic       busy  [NI];

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]  d;
        bit          pe;
        bit          fe;
        int unsigned stamp;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    uart_rx_deserializer #(.SAMPLE_RATIO(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MAJORITY(1)) dut0 (
        .sample_clk(clk), .rst_n(rst_n), .din(din[0]), .data(data[0]), .data_valid(dv[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .sample_sig(ss[0]), .busy(busy[0]));

    uart_rx_deserializer #(.SAMPLE_RATIO(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .MAJORITY(1)) dut1 (
        .sample_clk(clk), .rst_n(rst_n), .din(din[1]), .data(data[1]), .data_valid(dv[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .sample_sig(ss[1]), .busy(busy[1]));

    uart_rx_deserializer #(.SAMPLE_RATIO(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .MAJORITY(0)) dut2 (
        .sample_clk(clk), .rst_n(rst_n), .din(din[2]), .data(data[2]), .data_valid(dv[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .sample_sig(ss[2]), .busy(busy[2]));

    function automatic int cfg_sr(int i);   return (i == 2) ? 8 : 16;              endfunction
    function automatic int cfg_par(int i);  return (i == 1) ? 2 : ((i == 2) ? 1 : 0); endfunction
    function automatic int cfg_stop(int i); return (i == 1) ? 2 : 1;               endfunction
    function automatic int cfg_maj(int i);  return (i == 2) ? 0 : 1;               endfunction

    function automatic void check(string name, int i, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0h expected %0h", name, i, act, exp);
    endfunction

    function automatic void sb_push(int i, exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int sb_size(int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic bit sb_pop(int i, output exp_t e);
        e = '{d: 8'h00, pe: 1'b0, fe: 1'b0, stamp: 0};
        if (sb_size(i) == 0) return 1'b0;
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        return 1'b1;
    endfunction

    task automatic drive(int i, logic v, int n);
        repeat (n) begin
            @(negedge clk);
            din[i] = v;
        end
    endtask

    // One frame on line i. glitch >= 0 inverts the single sample at the centre
    // of that data bit; hold > 0 keeps the line low after a bad final stop bit.
    task automatic send_frame(int i, logic [7:0] d, bit bad_par, bit [1:0] stop_bad,
                              int glitch, int hold);
        int   sr    = cfg_sr(i);
        int   par   = cfg_par(i);
        int   nstop = cfg_stop(i);
        int   ones;
        int   lat;
        logic pbit;
        logic v;
        logic [7:0] rx;
        exp_t e;

        rx = d;
        if (glitch >= 0 && cfg_maj(i) == 0) rx[glitch] = ~rx[glitch];
        // Transmitter-side parity bit for the word actually sent.
        pbit = (par == 1) ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
        if (bad_par) pbit = ~pbit;
        ones = $countones(rx) + int'(pbit);
        e.d  = rx;
        e.pe = (par == 1) ? (ones % 2 == 0) : ((par == 2) ? (ones % 2 == 1) : 1'b0);
        e.fe = stop_bad[0] | ((nstop == 2) && stop_bad[1]);
        lat  = sr / 2 + sr * (8 + ((par != 0) ? 1 : 0) + nstop);

        @(negedge clk);
        e.stamp = cyc + 1 + lat;
        sb_push(i, e);
        din[i] = 1'b0;
        drive(i, 1'b0, sr - 1);
        for (int j = 0; j < 8; j++) begin
            for (int c = 0; c < sr; c++) begin
                @(negedge clk);
                din[i] = (glitch == j && c == sr / 2) ? ~d[j] : d[j];
            end
        end
        if (par != 0) drive(i, pbit, sr);
        for (int s = 0; s < nstop; s++) begin
            v = ~stop_bad[s];
            if (s == nstop - 1 && v) drive(i, 1'b1, $urandom_range(sr, sr / 2 + 1));
            else drive(i, v, sr);
        end
        if (stop_bad[nstop - 1]) begin
            drive(i, 1'b0, hold);
            check("brk_busy", i, 32'(busy[i]), 32'd1);
            drive(i, 1'b1, 2);
            check("brk_exit", i, 32'(busy[i]), 32'd0);
        end
    endtask

    task automatic runt(int i);
        int sr = cfg_sr(i);
        int n  = (sr == 16) ? 5 : 2;
        drive(i, 1'b0, n);
        check("runt_busy", i, 32'(busy[i]), 32'd1);
        drive(i, 1'b1, sr);
        check("runt_idle", i, 32'(busy[i]), 32'd0);
    endtask

    task automatic directed(int i);
        send_frame(i, 8'hA5, 1'b0, 2'b00, -1, 0);
        send_frame(i, 8'h07, 1'b1, 2'b00, -1, 0);
        runt(i);
        send_frame(i, 8'hFF, 1'b0, 2'b00, 3, 0);
        send_frame(i, 8'h5C, 1'b0, 2'b11, -1, 40);
    endtask

    task automatic random_frames(int i, int n);
        bit [1:0] sb;
        int g;
        for (int k = 0; k < n; k++) begin
            sb = ($urandom_range(5, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            g  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            send_frame(i, 8'($urandom), ($urandom_range(3, 0) == 0), sb, g, int'($urandom_range(20, 0)));
        end
        send_frame(i, 8'hC3, 1'b0, 2'b00, -1, 0);
    endtask

    task automatic partial(int i);
        logic [7:0] d = 8'h5A;
        drive(i, 1'b0, cfg_sr(i));
        for (int j = 0; j < 3; j++) drive(i, d[j], cfg_sr(i));
    endtask

    task automatic check_outputs_zero(string name);
        for (int i = 0; i < NI; i++) begin
            check({name, "_data"}, i, 32'(data[i]), 32'd0);
            check({name, "_valid"}, i, 32'(dv[i]), 32'd0);
            check({name, "_perr"}, i, 32'(pe[i]), 32'd0);
            check({name, "_ferr"}, i, 32'(fe[i]), 32'd0);
            check({name, "_sample"}, i, 32'(ss[i]), 32'd0);
            check({name, "_busy"}, i, 32'(busy[i]), 32'd0);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops one expected frame per data_valid pulse.
    initial begin
        int   scount [NI];
        exp_t e;
        for (int i = 0; i < NI; i++) scount[i] = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                for (int i = 0; i < NI; i++) scount[i] = 0;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    if (ss[i] === 1'b1) scount[i]++;
                    if (dv[i] === 1'b1) begin
                        if (sb_pop(i, e)) begin
                            check("data", i, 32'(data[i]), 32'(e.d));
                            check("parity_err", i, 32'(pe[i]), 32'(e.pe));
                            check("frame_err", i, 32'(fe[i]), 32'(e.fe));
                            check("latency", i, cyc, e.stamp);
                            check("sample_pulses", i, 32'(scount[i]), 32'd8);
                        end else begin
                            n_checks++;
                            $display("FAIL unexpected_valid inst%0d: got data %0h, expected no frame", i, data[i]);
                        end
                        scount[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int budget;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) din[i] = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        fork
            begin directed(0); random_frames(0, 25); end
            begin directed(1); random_frames(1, 25); end
            begin directed(2); random_frames(2, 25); end
        join
        repeat (4) @(negedge clk);

        fork
            partial(0);
            partial(1);
            partial(2);
        join
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        for (int i = 0; i < NI; i++) din[i] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        fork
            send_frame(0, 8'h3C, 1'b0, 2'b00, -1, 0);
            send_frame(1, 8'h3C, 1'b0, 2'b00, -1, 0);
            send_frame(2, 8'h3C, 1'b0, 2'b00, -1, 0);
        join

        budget = 400;
        while (budget > 0 && (sb_size(0) + sb_size(1) + sb_size(2)) != 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) check("drain", i, 32'(sb_size(i)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
